// File: rtl/ddr_ctr_rd_burst_test.sv
// DDR read-burst self-test: issues NUM_TXN AXI read bursts at a fixed stride and
// checks that every returned beat carries its own byte address.
module ddr_ctr_rd_burst_test #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8100_0000,
  parameter int                BURST_LEN = 8,
  parameter int                NUM_TXN   = 4,
  parameter int                STRIDE    = BURST_LEN * DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_ready,
  input  logic              start,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [15:0]       txn_cnt
);

  localparam int SUM_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_txn_idx;
  logic [7:0]        r_beat_idx;
  logic [SUM_W-1:0]  r_burst_addr;
  logic [SUM_W-1:0]  r_beat_addr;
  logic [15:0]       r_err_cnt;
  logic [15:0]       r_txn_cnt;
  logic              r_done;
  logic              r_pass;

  logic              w_ar_hs;
  logic              w_beat;
  logic              w_last_idx;
  logic              w_burst_end;
  logic              w_beat_err;
  logic              w_more;
  logic              w_restart;
  logic [DATA_W-1:0] w_exp_data;
  logic [15:0]       w_err_nxt;

  assign w_ar_hs     = (r_state == S_AR) && arready;
  assign w_beat      = (r_state == S_R) && rvalid;
  assign w_last_idx  = (r_beat_idx == 8'(BURST_LEN - 1));
  assign w_burst_end = w_beat && (rlast || w_last_idx);
  assign w_more      = ({1'b0, r_txn_idx} + 17'd1) < 17'(NUM_TXN);
  assign w_restart   = (r_state == S_DONE) && start;

  // Expected data is the beat's own byte address, truncated/extended to DATA_W.
  assign w_exp_data  = r_beat_addr[DATA_W-1:0];
  assign w_beat_err  = (rdata != w_exp_data) || (rresp != 2'b00) || (rlast != w_last_idx);
  assign w_err_nxt   = (w_beat && w_beat_err && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1
                                                                         : r_err_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the next state is defaulted first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ddr_ready) w_state_nxt = S_AR;
      S_AR:   if (arready)   w_state_nxt = S_R;
      S_R:    if (w_burst_end) w_state_nxt = w_more ? S_AR : S_DONE;
      S_DONE: if (start)     w_state_nxt = ddr_ready ? S_AR : S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn_idx    <= '0;
      r_beat_idx   <= '0;
      r_burst_addr <= SUM_W'(BASE_ADDR);
      r_beat_addr  <= SUM_W'(BASE_ADDR);
      r_err_cnt    <= '0;
      r_txn_cnt    <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (w_restart) begin
        r_txn_idx    <= '0;
        r_txn_cnt    <= '0;
        r_err_cnt    <= '0;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_burst_addr <= SUM_W'(BASE_ADDR);
      end
      if (w_ar_hs) begin
        r_beat_idx  <= '0;
        r_beat_addr <= r_burst_addr;
      end
      if (w_beat) begin
        r_beat_idx  <= r_beat_idx + 8'd1;
        r_beat_addr <= r_beat_addr + SUM_W'(BYTES);
        r_err_cnt   <= w_err_nxt;
      end
      if (w_burst_end) begin
        r_txn_cnt    <= r_txn_cnt + 16'd1;
        r_txn_idx    <= r_txn_idx + 16'd1;
        r_burst_addr <= r_burst_addr + SUM_W'(STRIDE);
        if (!w_more) begin
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == 16'd0);
        end
      end
    end
  end

  // arvalid is driven only from AR, so a second read can never overlap a burst.
  assign araddr  = r_burst_addr[ADDR_W-1:0];
  assign arlen   = 8'(BURST_LEN - 1);
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);
  assign busy    = (r_state == S_AR) || (r_state == S_R);
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err_cnt;
  assign txn_cnt = r_txn_cnt;

endmodule
